// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand_fetch decode-stage reader.
// Contents: RV32I major opcodes, FSM state encoding, the 32-bit zero
// word, and the source-register need decoder used by the top level.
package operand_fetch_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Returns {rs2_needed, rs1_needed}. Unknown opcodes need nothing.
    function automatic logic [1:0] src_need(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH:  src_need = 2'b11;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: src_need = 2'b01;
            default:                        src_need = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_imm_gen.sv
// Immediate generator for operand_fetch (purely combinational).
// Ports:
//   inst_i    : RV32I instruction word
//   imm_o     : sign-extended immediate for the instruction's format
//               (zero for R-type and unknown opcodes)
//   illegal_o : opcode is not one of the supported RV32I major opcodes
module operand_fetch_imm_gen
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       inst_i,
    output logic [DATA_W-1:0] imm_o,
    output logic              illegal_o
);

    logic [31:0] imm32;
    logic        unused_funct3;

    // funct3 does not take part in immediate selection.
    assign unused_funct3 = ^inst_i[14:12];

    always_comb begin
        imm32     = ZERO_WORD;
        illegal_o = 1'b0;
        case (inst_i[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            OPC_STORE:
                imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OPC_BRANCH:
                imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {inst_i[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                         inst_i[20], inst_i[30:21], 1'b0};
            OPC_OP:
                imm32 = ZERO_WORD;
            default:
                illegal_o = 1'b1;
        endcase
    end

    assign imm_o = DATA_W'($signed(imm32));

endmodule

// File: rtl/operand_fetch.sv
// Decode-stage operand reader for a two-read-port register file.
// Latches one RV32I instruction from IF/ID, requests the source registers
// it needs, waits out register-file hazards (rvalid low), and presents a
// decoded bundle to EX.
// Ports:
//   clk_in, rst_in (sync, active-low)
//   inst_valid_in/inst_ready_out, inst_in, pc_in : IF/ID side
//   flush_in                                     : branch redirect
//   re*/raddr*/rdata*/rvalid*                    : register-file read ports
//   ex_valid_out/ex_ready_in, ex_*               : EX-side bundle
//   stall_cnt_out                                : hazard-stall cycle count
//   state_dbg_out                                : current FSM state
//
// Handshakes (both sides): a transfer happens on a rising clk_in edge where
// valid and ready are both 1. A producer holding valid keeps its payload
// stable until the transfer; ready may depend combinationally on the
// consumer's own ready but never on valid.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              inst_valid_in,
    input  logic [31:0]       inst_in,
    input  logic [31:0]       pc_in,
    output logic              inst_ready_out,
    input  logic              flush_in,
    output logic              re1_out,
    output logic [REG_AW-1:0] raddr1_out,
    input  logic [DATA_W-1:0] rdata1_in,
    input  logic              rvalid1_in,
    output logic              re2_out,
    output logic [REG_AW-1:0] raddr2_out,
    input  logic [DATA_W-1:0] rdata2_in,
    input  logic              rvalid2_in,
    output logic              ex_valid_out,
    input  logic              ex_ready_in,
    output logic [DATA_W-1:0] ex_op1_out,
    output logic [DATA_W-1:0] ex_op2_out,
    output logic [DATA_W-1:0] ex_imm_out,
    output logic [31:0]       ex_pc_out,
    output logic [REG_AW-1:0] ex_rd_out,
    output logic              ex_wreg_out,
    output logic [6:0]        ex_opcode_out,
    output logic [2:0]        ex_funct3_out,
    output logic              ex_funct7b5_out,
    output logic              ex_illegal_out,
    output logic [CNT_W-1:0]  stall_cnt_out,
    output logic [1:0]        state_dbg_out
);

    state_e              state_q;
    logic [31:0]         inst_q, pc_q;
    logic                got1_q, got2_q;
    logic [DATA_W-1:0]   op1_q, op2_q;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic [DATA_W-1:0]   ex_op1_q, ex_op2_q, ex_imm_q;
    logic [31:0]         ex_pc_q;
    logic [REG_AW-1:0]   ex_rd_q;
    logic                ex_wreg_q, ex_f7b5_q, ex_illegal_q;
    logic [6:0]          ex_opcode_q;
    logic [2:0]          ex_funct3_q;

    logic [1:0]          need;
    logic                in_read, take1, take2, got1_d, got2_d;
    logic                done, stall_hit, accept, wreg, illegal;
    logic [DATA_W-1:0]   op1_d, op2_d, imm;

    operand_fetch_imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
        .inst_i    (inst_q),
        .imm_o     (imm),
        .illegal_o (illegal)
    );

    assign need    = src_need(inst_q[6:0]);
    assign in_read = (state_q == ST_READ);

    // A port captures only once; later rvalid pulses cannot overwrite it.
    assign take1  = in_read && need[0] && !got1_q && rvalid1_in;
    assign take2  = in_read && need[1] && !got2_q && rvalid2_in;
    assign got1_d = got1_q | take1;
    assign got2_d = got2_q | take2;
    assign op1_d  = take1 ? rdata1_in : op1_q;
    assign op2_d  = take2 ? rdata2_in : op2_q;

    // Completion counts this cycle's captures, so a clean read takes 1 cycle.
    assign done      = (!need[0] || got1_d) && (!need[1] || got2_d);
    assign stall_hit = in_read && ((need[0] && !got1_q && !rvalid1_in) ||
                                   (need[1] && !got2_q && !rvalid2_in));

    assign wreg = !illegal && (inst_q[6:0] != OPC_BRANCH) &&
                  (inst_q[6:0] != OPC_STORE) && (inst_q[11:7] != 5'd0);

    assign inst_ready_out = rst_in && !flush_in &&
                            ((state_q == ST_IDLE) ||
                             ((state_q == ST_HOLD) && ex_ready_in));
    assign accept = inst_valid_in && inst_ready_out;

    assign re1_out    = in_read && need[0];
    assign re2_out    = in_read && need[1];
    assign raddr1_out = re1_out ? REG_AW'(inst_q[19:15]) : '0;
    assign raddr2_out = re2_out ? REG_AW'(inst_q[24:20]) : '0;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= ST_IDLE;
            inst_q       <= '0;
            pc_q         <= '0;
            got1_q       <= 1'b0;
            got2_q       <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            stall_cnt_q  <= '0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_imm_q     <= '0;
            ex_pc_q      <= '0;
            ex_rd_q      <= '0;
            ex_wreg_q    <= 1'b0;
            ex_opcode_q  <= '0;
            ex_funct3_q  <= '0;
            ex_f7b5_q    <= 1'b0;
            ex_illegal_q <= 1'b0;
        end else if (flush_in) begin
            // The stall counter is a performance statistic and survives flush.
            state_q <= ST_IDLE;
            got1_q  <= 1'b0;
            got2_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_q <= ST_READ;
                end
                ST_READ: begin
                    got1_q <= got1_d;
                    got2_q <= got2_d;
                    op1_q  <= op1_d;
                    op2_q  <= op2_d;
                    if (stall_hit) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    if (done) begin
                        state_q      <= ST_HOLD;
                        ex_op1_q     <= op1_d;
                        ex_op2_q     <= op2_d;
                        ex_imm_q     <= imm;
                        ex_pc_q      <= pc_q;
                        ex_rd_q      <= REG_AW'(inst_q[11:7]);
                        ex_wreg_q    <= wreg;
                        ex_opcode_q  <= inst_q[6:0];
                        ex_funct3_q  <= inst_q[14:12];
                        ex_f7b5_q    <= inst_q[30];
                        ex_illegal_q <= illegal;
                    end
                end
                ST_HOLD: begin
                    if (ex_ready_in) state_q <= accept ? ST_READ : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            // A new instruction starts with clean capture state so unneeded
            // operands read as zero and nothing stale leaks through.
            if (accept) begin
                inst_q <= inst_in;
                pc_q   <= pc_in;
                got1_q <= 1'b0;
                got2_q <= 1'b0;
                op1_q  <= '0;
                op2_q  <= '0;
            end
        end
    end

    assign ex_valid_out    = (state_q == ST_HOLD);
    assign ex_op1_out      = ex_op1_q;
    assign ex_op2_out      = ex_op2_q;
    assign ex_imm_out      = ex_imm_q;
    assign ex_pc_out       = ex_pc_q;
    assign ex_rd_out       = ex_rd_q;
    assign ex_wreg_out     = ex_wreg_q;
    assign ex_opcode_out   = ex_opcode_q;
    assign ex_funct3_out   = ex_funct3_q;
    assign ex_funct7b5_out = ex_f7b5_q;
    assign ex_illegal_out  = ex_illegal_q;
    assign stall_cnt_out   = stall_cnt_q;
    assign state_dbg_out   = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    // Opcodes written out independently of the design package.
    localparam logic [6:0] B_OP     = 7'h33;
    localparam logic [6:0] B_OP_IMM = 7'h13;
    localparam logic [6:0] B_LOAD   = 7'h03;
    localparam logic [6:0] B_STORE  = 7'h23;
    localparam logic [6:0] B_BRANCH = 7'h63;
    localparam logic [6:0] B_JAL    = 7'h6F;
    localparam logic [6:0] B_JALR   = 7'h67;
    localparam logic [6:0] B_LUI    = 7'h37;
    localparam logic [6:0] B_AUIPC  = 7'h17;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wreg;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5;
        logic        illegal;
    } bundle_t;
    localparam int BW = $bits(bundle_t);

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, inst_valid, flush, rv1, rv2, ex_ready;
    logic [31:0] inst, pc, rd1, rd2;
    logic        inst_ready_out, re1_out, re2_out, ex_valid_out;
    logic [4:0]  raddr1_out, raddr2_out, ex_rd_out;
    logic [31:0] ex_op1_out, ex_op2_out, ex_imm_out, ex_pc_out, stall_cnt_out;
    logic        ex_wreg_out, ex_funct7b5_out, ex_illegal_out;
    logic [6:0]  ex_opcode_out;
    logic [2:0]  ex_funct3_out;
    logic [1:0]  state_dbg_out;

    operand_fetch #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
        .clk_in(clk), .rst_in(rst_n),
        .inst_valid_in(inst_valid), .inst_in(inst), .pc_in(pc),
        .inst_ready_out(inst_ready_out), .flush_in(flush),
        .re1_out(re1_out), .raddr1_out(raddr1_out), .rdata1_in(rd1), .rvalid1_in(rv1),
        .re2_out(re2_out), .raddr2_out(raddr2_out), .rdata2_in(rd2), .rvalid2_in(rv2),
        .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready),
        .ex_op1_out(ex_op1_out), .ex_op2_out(ex_op2_out), .ex_imm_out(ex_imm_out),
        .ex_pc_out(ex_pc_out), .ex_rd_out(ex_rd_out), .ex_wreg_out(ex_wreg_out),
        .ex_opcode_out(ex_opcode_out), .ex_funct3_out(ex_funct3_out),
        .ex_funct7b5_out(ex_funct7b5_out), .ex_illegal_out(ex_illegal_out),
        .stall_cnt_out(stall_cnt_out), .state_dbg_out(state_dbg_out)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 = free, 1 = reading registers, 2 = bundle offered to EX.
    int          m_phase;
    logic [31:0] m_inst, m_pc, m_op1, m_op2, m_stall;
    bit          m_g1, m_g2;
    bundle_t     m_ex;
    logic [BW-1:0] exp_q[$];

    function automatic bit ref_known(input logic [6:0] o);
        return o inside {B_OP, B_OP_IMM, B_LOAD, B_STORE, B_BRANCH,
                         B_JAL, B_JALR, B_LUI, B_AUIPC};
    endfunction

    // {rs2 needed, rs1 needed}
    function automatic logic [1:0] ref_need(input logic [6:0] o);
        if (o == B_OP || o == B_STORE || o == B_BRANCH) return 2'b11;
        if (o == B_OP_IMM || o == B_LOAD || o == B_JALR) return 2'b01;
        return 2'b00;
    endfunction

    // Immediates built by shifting and masking; sx replicates bit 31.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] sx;
        sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (i[6:0])
            B_OP_IMM, B_LOAD, B_JALR: return (sx << 11) | 32'(i[30:20]);
            B_STORE:  return (sx << 11) | (32'(i[30:25]) << 5) | 32'(i[11:7]);
            B_BRANCH: return (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
                             | (32'(i[11:8]) << 1);
            B_LUI, B_AUIPC: return i & 32'hFFFF_F000;
            B_JAL:    return (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
                             | (32'(i[30:21]) << 1);
            default:  return 32'h0;
        endcase
    endfunction

    function automatic bundle_t ref_bundle(input logic [31:0] i, input logic [31:0] p,
                                           input logic [31:0] a, input logic [31:0] b);
        bundle_t r;
        r.op1     = a;
        r.op2     = b;
        r.imm     = ref_imm(i);
        r.pc      = p;
        r.rd      = i[11:7];
        r.wreg    = ref_known(i[6:0]) && i[6:0] != B_BRANCH && i[6:0] != B_STORE
                    && i[11:7] != 5'd0;
        r.opc     = i[6:0];
        r.f3      = i[14:12];
        r.f7b5    = i[30];
        r.illegal = !ref_known(i[6:0]);
        return r;
    endfunction

    task automatic m_load();
        m_inst  = inst;
        m_pc    = pc;
        m_g1    = 0;
        m_g2    = 0;
        m_op1   = 0;
        m_op2   = 0;
        m_phase = 1;
    endtask

    task automatic model_step();
        logic [1:0] nd;
        if (!rst_n) begin
            m_phase = 0; m_inst = 0; m_pc = 0; m_g1 = 0; m_g2 = 0;
            m_op1 = 0; m_op2 = 0; m_stall = 0; m_ex = '0;
            exp_q.delete();
        end else if (flush) begin
            if (m_phase == 2) exp_q.delete();
            m_phase = 0; m_g1 = 0; m_g2 = 0;
        end else begin
            case (m_phase)
                0: if (inst_valid) m_load();
                1: begin
                    nd = ref_need(m_inst[6:0]);
                    if ((nd[0] && !m_g1 && !rv1) || (nd[1] && !m_g2 && !rv2)) m_stall++;
                    if (nd[0] && !m_g1 && rv1) begin m_op1 = rd1; m_g1 = 1; end
                    if (nd[1] && !m_g2 && rv2) begin m_op2 = rd2; m_g2 = 1; end
                    if ((!nd[0] || m_g1) && (!nd[1] || m_g2)) begin
                        m_ex = ref_bundle(m_inst, m_pc, m_op1, m_op2);
                        exp_q.push_back(m_ex);
                        m_phase = 2;
                    end
                end
                default: if (ex_ready) begin
                    if (inst_valid) m_load();
                    else m_phase = 0;
                end
            endcase
        end
    endtask

    // ---------------- per-cycle comparison + scoreboard ----------------
    task automatic compare_all();
        logic [1:0]    nd;
        logic [BW-1:0] dut_b, exp_b;
        nd = (m_phase == 1) ? ref_need(m_inst[6:0]) : 2'b00;
        check_eq("inst_ready", inst_ready_out,
                 rst_n && !flush && (m_phase == 0 || (m_phase == 2 && ex_ready)));
        check_eq("re1", re1_out, nd[0]);
        check_eq("re2", re2_out, nd[1]);
        check_eq("raddr1", raddr1_out, nd[0] ? m_inst[19:15] : 5'd0);
        check_eq("raddr2", raddr2_out, nd[1] ? m_inst[24:20] : 5'd0);
        check_eq("ex_valid", ex_valid_out, m_phase == 2);
        check_eq("ex_op1", ex_op1_out, m_ex.op1);
        check_eq("ex_op2", ex_op2_out, m_ex.op2);
        check_eq("ex_imm", ex_imm_out, m_ex.imm);
        check_eq("ex_pc", ex_pc_out, m_ex.pc);
        check_eq("ex_rd", ex_rd_out, m_ex.rd);
        check_eq("ex_wreg", ex_wreg_out, m_ex.wreg);
        check_eq("ex_opcode", ex_opcode_out, m_ex.opc);
        check_eq("ex_funct3", ex_funct3_out, m_ex.f3);
        check_eq("ex_f7b5", ex_funct7b5_out, m_ex.f7b5);
        check_eq("ex_illegal", ex_illegal_out, m_ex.illegal);
        check_eq("stall_cnt", stall_cnt_out, m_stall);
        if (ex_valid_out === 1'b1 && ex_ready && rst_n && !flush) begin
            check_eq("sb_avail", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                dut_b = {ex_op1_out, ex_op2_out, ex_imm_out, ex_pc_out, ex_rd_out,
                         ex_wreg_out, ex_opcode_out, ex_funct3_out, ex_funct7b5_out,
                         ex_illegal_out};
                check_eq("sb_bundle", dut_b, exp_b);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic peek();
        #1;
    endtask

    task automatic cycle();
        #2;
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        inst_valid = 0; flush = 0; rv1 = 0; rv2 = 0;
        rd1 = 32'h0; rd2 = 32'h0; ex_ready = 1; inst = 32'h0; pc = 32'h0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: w[6:0] = B_OP;     1: w[6:0] = B_OP_IMM; 2: w[6:0] = B_LOAD;
            3: w[6:0] = B_STORE;  4: w[6:0] = B_BRANCH; 5: w[6:0] = B_JAL;
            6: w[6:0] = B_JALR;   7: w[6:0] = B_LUI;    8: w[6:0] = B_AUIPC;
            9: w[6:0] = B_OP;
            default: w[6:0] = 7'($urandom);
        endcase
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    task automatic drive_random();
        rst_n      = ($urandom_range(0, 99) != 0);
        flush      = ($urandom_range(0, 24) == 0);
        inst_valid = $urandom_range(0, 1);
        inst       = rand_inst();
        pc         = $urandom & 32'hFFFF_FFFC;
        ex_ready   = ($urandom_range(0, 3) != 0);
        rv1        = ($urandom_range(0, 9) < 7);
        rv2        = ($urandom_range(0, 9) < 7);
        rd1        = $urandom;
        rd2        = $urandom;
    endtask

    // ---------------- test sequence ----------------
    logic [31:0] stall0;

    initial begin
        idle_inputs();
        rst_n = 0;
        inst_valid = 1;
        inst = 32'h0020_81B3;
        @(posedge clk);
        model_step();
        #1;

        // Reset held: nothing accepted, everything cleared.
        repeat (2) begin
            peek();
            check_eq("rst_ready", inst_ready_out, 1'b0);
            check_eq("rst_ex_valid", ex_valid_out, 1'b0);
            check_eq("rst_re", {re1_out, re2_out}, 2'b00);
            check_eq("rst_stall", stall_cnt_out, 32'd0);
            check_eq("rst_ex_op1", ex_op1_out, 32'd0);
            cycle();
        end

        // ADD x3,x1,x2 accepted right out of reset.
        rst_n = 1; pc = 32'h100; rd1 = 32'd5; rd2 = 32'd7; rv1 = 1; rv2 = 1;
        peek();
        check_eq("add_accept", inst_ready_out, 1'b1);
        cycle();
        inst_valid = 0;
        peek();
        check_eq("add_re", {re1_out, re2_out}, 2'b11);
        check_eq("add_raddr1", raddr1_out, 5'd1);
        check_eq("add_raddr2", raddr2_out, 5'd2);
        cycle();
        peek();
        check_eq("add_valid", ex_valid_out, 1'b1);
        check_eq("add_op1", ex_op1_out, 32'd5);
        check_eq("add_op2", ex_op2_out, 32'd7);
        check_eq("add_rd", ex_rd_out, 5'd3);
        check_eq("add_wreg", ex_wreg_out, 1'b1);
        check_eq("add_opcode", ex_opcode_out, 7'h33);
        cycle();

        // ADDI x5,x1,-1: rs1 only.
        inst_valid = 1; inst = 32'hFFF0_8293; pc = 32'h104; rd1 = 32'h20; rd2 = 32'h1234;
        cycle();
        inst_valid = 0;
        peek();
        check_eq("addi_re2", re2_out, 1'b0);
        check_eq("addi_re1", re1_out, 1'b1);
        cycle();
        peek();
        check_eq("addi_imm", ex_imm_out, 32'hFFFF_FFFF);
        check_eq("addi_op2", ex_op2_out, 32'd0);
        check_eq("addi_op1", ex_op1_out, 32'h20);
        check_eq("addi_wreg", ex_wreg_out, 1'b1);
        check_eq("addi_rd", ex_rd_out, 5'd5);
        cycle();

        // Hazard on port 1 for three cycles; port 2 captured early.
        stall0 = m_stall;
        inst_valid = 1; inst = 32'h0020_81B3; pc = 32'h108; rv1 = 0; rv2 = 0;
        cycle();
        inst_valid = 0; rv2 = 1; rd2 = 32'd9; rd1 = 32'hBAD;
        cycle();
        rv2 = 0; rd2 = 32'hBEEF;
        cycle();
        cycle();
        rv1 = 1; rd1 = 32'h10; ex_ready = 0;
        peek();
        check_eq("hz_not_yet", ex_valid_out, 1'b0);
        cycle();
        peek();
        check_eq("hz_valid", ex_valid_out, 1'b1);
        check_eq("hz_op1", ex_op1_out, 32'h10);
        check_eq("hz_op2", ex_op2_out, 32'd9);
        check_eq("hz_stall", stall_cnt_out, stall0 + 32'd3);

        // Back-pressure: EX stalls 4 cycles while LUI x9 waits at IF/ID.
        inst_valid = 1; inst = 32'h1234_54B7; pc = 32'h10C;
        repeat (4) begin
            peek();
            check_eq("bp_ready", inst_ready_out, 1'b0);
            check_eq("bp_valid", ex_valid_out, 1'b1);
            check_eq("bp_op1", ex_op1_out, 32'h10);
            cycle();
        end
        ex_ready = 1;
        peek();
        check_eq("bp_accept", inst_ready_out, 1'b1);
        cycle();
        inst_valid = 0;
        peek();
        check_eq("bp_drop", ex_valid_out, 1'b0);
        cycle();
        peek();
        check_eq("lui_imm", ex_imm_out, 32'h1234_5000);
        check_eq("lui_rd", ex_rd_out, 5'd9);
        cycle();

        // Flush during READ with a new instruction offered.
        inst_valid = 1; inst = 32'h0020_81B3; pc = 32'h200; rv1 = 0; rv2 = 0;
        cycle();
        flush = 1; inst = 32'h0053_8313; pc = 32'h300; rv2 = 1; rd2 = 32'h55;
        peek();
        check_eq("fl_ready", inst_ready_out, 1'b0);
        cycle();
        flush = 0; rv1 = 1; rd1 = 32'h33; rv2 = 1; rd2 = 32'h99;
        peek();
        check_eq("fl_state", state_dbg_out, ST_IDLE);
        check_eq("fl_re", {re1_out, re2_out}, 2'b00);
        check_eq("fl_valid", ex_valid_out, 1'b0);
        cycle();
        inst_valid = 0;
        peek();
        check_eq("fl_raddr1", raddr1_out, 5'd7);
        check_eq("fl_re2", re2_out, 1'b0);
        cycle();
        peek();
        check_eq("fl_op1", ex_op1_out, 32'h33);
        check_eq("fl_op2", ex_op2_out, 32'd0);
        check_eq("fl_imm", ex_imm_out, 32'd5);
        check_eq("fl_pc", ex_pc_out, 32'h300);
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            drive_random();
            cycle();
        end

        // Drain: let any held bundle leave.
        idle_inputs();
        rst_n = 1;
        repeat (6) cycle();
        check_eq("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
